cva6_lsu_queue_model: RTL and testbench
=======================================

# cva6_lsu_queue_model

Parametrised successor to the single-outstanding CVA6 LSU behavioural model. Tracks up to LQ_DEPTH in-flight loads and SQ_DEPTH in-flight stores as in-order address FIFOs and retires them on memory responses. Stalls loads that alias a pending store (RAW hazard). Sits between the issue stimulus and the memory-response model in the LSU lifting/equivalence benches, and is compared cycle-by-cycle against the LSU shim.

## Interface
- ADDR_W, 32: request address width; must be ≥ 3.
- LQ_DEPTH, 2: load queue entries; ≥ 1, power of two not required.
- SQ_DEPTH, 2: store queue entries; ≥ 1, power of two not required.
- CW = $clog2(max(LQ_DEPTH, SQ_DEPTH)+1): count width; derived, not overridable.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- instr_i  in  ADDR_W  request address.
- is_load_i  in  1  1 = load, 0 = store.
- instr_valid_i  in  1  request valid.
- load_mem_resp_i  in  1  one-cycle pulse; retires oldest load.
- store_mem_resp_i  in  1  one-cycle pulse; retires oldest store.
- ready_o  out  1  presented request can be accepted this cycle.
- raw_stall_o  out  1  presented load blocked by a store alias.
- lq_count_o  out  CW  occupied load entries.
- sq_count_o  out  CW  occupied store entries.
- lq_head_addr_o  out  ADDR_W  oldest pending load address; 0 when empty.
- resp_err_o  out  1  sticky: response seen with its queue empty.

## Operation
- Two circular FIFOs: load FIFO and store FIFO. Each has a head pointer, a tail pointer and a count. Pointers wrap from DEPTH-1 to 0.
- Word alias: a load aliases a store entry when instr_i[ADDR_W-1:2] equals the entry's address bits [ADDR_W-1:2] and the entry is occupied. Byte offset bits [1:0] are ignored.
- raw_stall_o = is_load_i & (any occupied store entry aliases instr_i). This is combinational on the registered contents and on the current inputs. It is independent of instr_valid_i.
- ready_o is combinational on registered state:
  - load presented: ready_o = !lq_full & !raw_stall_o.
  - store presented: ready_o = !sq_full.
- Accept condition: instr_valid_i & ready_o. On accept, instr_i is written at the tail of the selected FIFO, then the tail and the count increment.
- load_mem_resp_i with the load FIFO non-empty: head increments, count decrements. store_mem_resp_i behaves the same way for the store FIFO.
- A response with its FIFO empty is ignored and sets resp_err_o. resp_err_o clears only on reset.
- Stores never stall on loads. There is no store-to-load forwarding.

## Timing
- Reset (async assert): pointers, counts, FIFO contents, lq_head_addr_o and resp_err_o are all 0. While rst_i is high, ready_o = 0 and raw_stall_o = 0. On the first edge after deassert, ready_o reflects empty queues (1 for any request).
- Reset asserted mid-operation drops all in-flight entries immediately. No responses are owed after reset.
- Latency: an accepted request shows in the count, head address and hazard logic on the cycle after the accepting edge. A response retires the entry at that edge, and the count drops the next cycle.
- Simultaneous accept and response on the same FIFO: the count is unchanged and both pointers advance.
- Full FIFO plus response in the same cycle: ready_o is still 0 that cycle, because there is no same-cycle bypass. Acceptance resumes the next cycle.
- Store response and aliasing load in the same cycle: the load stays stalled, because the hazard is computed on pre-edge contents. The load is accepted one cycle later.
- Accept of a store and an aliasing load are never in the same cycle, because there is a single request port.
- When count = DEPTH, the full flag is set and further requests of that type hold ready_o = 0 until a response arrives.

## Test plan
- Reset, then store 0xcad, store_mem_resp_i 3 cycles later -> sq_count_o goes 0→1→0, ready_o = 1 throughout, resp_err_o = 0.
- LQ_DEPTH = 2: loads to 0x100, 0x200, 0x300 on back-to-back cycles -> first two accepted, third sees ready_o = 0. lq_head_addr_o = 0x100. After one load response, head = 0x200 and the third load is accepted the next cycle.
- Store 0xcad pending, then load 0xcac -> raw_stall_o = 1 and ready_o = 0. Load 0xcb0 -> ready_o = 1. Store response plus load 0xcac in the same cycle -> still stalled that cycle, accepted the next.
- SQ_DEPTH = 3 (non-power-of-two): 7 store/response pairs -> pointers wrap at 3, sq_count_o never exceeds 3, FIFO order preserved.
- load_mem_resp_i with an empty load queue -> lq_count_o stays 0 and resp_err_o = 1 until rst_i.
- Reset asserted with 2 loads and 1 store pending -> all counts 0 and ready_o = 0 immediately (asynchronous); ready_o = 1 after release.

Source files
------------

// File: rtl/cva6_lsu_queue_model_if.sv
// Request/response bundle for the LSU queue model: issue-side request,
// memory response pulses and the queue status that the shim is compared against.
interface cva6_lsu_queue_model_if #(
    parameter int ADDR_W   = 32,
    parameter int LQ_DEPTH = 2,
    parameter int SQ_DEPTH = 2
);
    localparam int CW = $clog2(((LQ_DEPTH > SQ_DEPTH) ? LQ_DEPTH : SQ_DEPTH) + 1);

    logic [ADDR_W-1:0] instr_i;
    logic              is_load_i;
    logic              instr_valid_i;
    logic              load_mem_resp_i;
    logic              store_mem_resp_i;
    logic              ready_o;
    logic              raw_stall_o;
    logic [CW-1:0]     lq_count_o;
    logic [CW-1:0]     sq_count_o;
    logic [ADDR_W-1:0] lq_head_addr_o;
    logic              resp_err_o;

    modport master (
        output instr_i, is_load_i, instr_valid_i, load_mem_resp_i, store_mem_resp_i,
        input  ready_o, raw_stall_o, lq_count_o, sq_count_o, lq_head_addr_o, resp_err_o
    );
    modport slave (
        input  instr_i, is_load_i, instr_valid_i, load_mem_resp_i, store_mem_resp_i,
        output ready_o, raw_stall_o, lq_count_o, sq_count_o, lq_head_addr_o, resp_err_o
    );
endinterface

// File: rtl/cva6_lsu_queue_model.sv
// LSU behavioural model: in-order load/store address FIFOs retired by memory
// response pulses, with word-granular RAW stall of loads behind pending stores.
module cva6_lsu_queue_model #(
    parameter int ADDR_W   = 32,
    parameter int LQ_DEPTH = 2,
    parameter int SQ_DEPTH = 2
) (
    input logic clk_i,
    input logic rst_i,
    cva6_lsu_queue_model_if.slave bus
);
    localparam int CW  = $clog2(((LQ_DEPTH > SQ_DEPTH) ? LQ_DEPTH : SQ_DEPTH) + 1);
    localparam int LPW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int SPW = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;

    logic [LQ_DEPTH-1:0][ADDR_W-1:0] lq_mem;
    // Stores only ever feed the word-alias compare, so byte offsets are not kept.
    logic [SQ_DEPTH-1:0][ADDR_W-1:2] sq_mem;
    logic [SQ_DEPTH-1:0]             sq_vld;
    logic [LPW-1:0]                  lq_hd, lq_tl;
    logic [SPW-1:0]                  sq_hd, sq_tl;
    logic [CW-1:0]                   lq_cnt, sq_cnt;
    logic                            resp_err;

    logic alias_hit, raw, ready, lq_full, sq_full;
    logic lq_acc, sq_acc, lq_ret, sq_ret;

    function automatic logic [LPW-1:0] lq_inc(input logic [LPW-1:0] p);
        return (p == LPW'(LQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [SPW-1:0] sq_inc(input logic [SPW-1:0] p);
        return (p == SPW'(SQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        alias_hit = 1'b0;
        for (int i = 0; i < SQ_DEPTH; i++)
            if (sq_vld[i] && (sq_mem[i] == bus.instr_i[ADDR_W-1:2])) alias_hit = 1'b1;
    end

    assign lq_full = (lq_cnt == CW'(LQ_DEPTH));
    assign sq_full = (sq_cnt == CW'(SQ_DEPTH));
    assign raw     = !rst_i && bus.is_load_i && alias_hit;
    // No same-cycle bypass: a response freeing a slot only helps from the next cycle.
    assign ready   = !rst_i && (bus.is_load_i ? (!lq_full && !raw) : !sq_full);

    assign lq_acc  = bus.instr_valid_i && ready &&  bus.is_load_i;
    assign sq_acc  = bus.instr_valid_i && ready && !bus.is_load_i;
    assign lq_ret  = bus.load_mem_resp_i  && (lq_cnt != '0);
    assign sq_ret  = bus.store_mem_resp_i && (sq_cnt != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lq_mem   <= '0;
            sq_mem   <= '0;
            sq_vld   <= '0;
            lq_hd    <= '0;
            lq_tl    <= '0;
            sq_hd    <= '0;
            sq_tl    <= '0;
            lq_cnt   <= '0;
            sq_cnt   <= '0;
            resp_err <= 1'b0;
        end else begin
            if (lq_acc) begin
                lq_mem[lq_tl] <= bus.instr_i;
                lq_tl         <= lq_inc(lq_tl);
            end
            if (lq_ret) lq_hd <= lq_inc(lq_hd);
            lq_cnt <= lq_cnt + CW'(lq_acc) - CW'(lq_ret);

            // Retire and accept never hit the same slot: that needs empty or full.
            if (sq_ret) begin
                sq_vld[sq_hd] <= 1'b0;
                sq_hd         <= sq_inc(sq_hd);
            end
            if (sq_acc) begin
                sq_mem[sq_tl] <= bus.instr_i[ADDR_W-1:2];
                sq_vld[sq_tl] <= 1'b1;
                sq_tl         <= sq_inc(sq_tl);
            end
            sq_cnt <= sq_cnt + CW'(sq_acc) - CW'(sq_ret);

            if ((bus.load_mem_resp_i && lq_cnt == '0) || (bus.store_mem_resp_i && sq_cnt == '0))
                resp_err <= 1'b1;
        end
    end

    assign bus.ready_o        = ready;
    assign bus.raw_stall_o    = raw;
    assign bus.lq_count_o     = lq_cnt;
    assign bus.sq_count_o     = sq_cnt;
    assign bus.lq_head_addr_o = (lq_cnt != '0) ? lq_mem[lq_hd] : '0;
    assign bus.resp_err_o     = resp_err;
endmodule

// File: tb/tb_cva6_lsu_queue_model.sv
// Directed bench for the LSU queue model: LQ_DEPTH=2, SQ_DEPTH=3 (non-power-of-two).
module tb_cva6_lsu_queue_model;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   nchk  = 0;
    int   nfail = 0;

    cva6_lsu_queue_model_if #(.ADDR_W(32), .LQ_DEPTH(2), .SQ_DEPTH(3)) bus ();

    cva6_lsu_queue_model #(.ADDR_W(32), .LQ_DEPTH(2), .SQ_DEPTH(3)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [31:0] a, input logic ld, input logic v);
        bus.instr_i       = a;
        bus.is_load_i     = ld;
        bus.instr_valid_i = v;
    endtask

    initial begin
        req(32'h0, 1'b0, 1'b1);
        bus.load_mem_resp_i  = 1'b0;
        bus.store_mem_resp_i = 1'b0;
        #2;
        chk("rst_ready",   32'(bus.ready_o), 0);
        chk("rst_raw",     32'(bus.raw_stall_o), 0);
        chk("rst_lqcnt",   32'(bus.lq_count_o), 0);
        chk("rst_sqcnt",   32'(bus.sq_count_o), 0);
        chk("rst_head",    bus.lq_head_addr_o, 0);
        chk("rst_err",     32'(bus.resp_err_o), 0);
        step();
        step();
        rst_i = 1'b0;
        req(32'h0, 1'b0, 1'b0);
        #1 chk("rel_ready", 32'(bus.ready_o), 1);

        // store 0xcad, response three cycles later
        step();
        req(32'hcad, 1'b0, 1'b1);
        #1 chk("st_ready", 32'(bus.ready_o), 1);
        step();
        bus.instr_valid_i = 1'b0;
        #1 chk("st_cnt1", 32'(bus.sq_count_o), 1);
        step();
        step();
        bus.store_mem_resp_i = 1'b1;
        #1 chk("st_cnt1b", 32'(bus.sq_count_o), 1);
        chk("st_ready2", 32'(bus.ready_o), 1);
        step();
        bus.store_mem_resp_i = 1'b0;
        #1 chk("st_cnt0", 32'(bus.sq_count_o), 0);
        chk("st_err", 32'(bus.resp_err_o), 0);

        // back-to-back loads fill the load queue
        req(32'h100, 1'b1, 1'b1);
        #1 chk("ld1_ready", 32'(bus.ready_o), 1);
        step();
        req(32'h200, 1'b1, 1'b1);
        #1 chk("ld2_ready", 32'(bus.ready_o), 1);
        chk("ld2_cnt", 32'(bus.lq_count_o), 1);
        chk("ld2_head", bus.lq_head_addr_o, 32'h100);
        step();
        req(32'h300, 1'b1, 1'b1);
        #1 chk("ld3_ready", 32'(bus.ready_o), 0);
        chk("ld3_cnt", 32'(bus.lq_count_o), 2);
        chk("ld3_head", bus.lq_head_addr_o, 32'h100);
        bus.load_mem_resp_i = 1'b1;
        #1 chk("full_resp_ready", 32'(bus.ready_o), 0);
        step();
        bus.load_mem_resp_i = 1'b0;
        #1 chk("ldr_cnt", 32'(bus.lq_count_o), 1);
        chk("ldr_head", bus.lq_head_addr_o, 32'h200);
        chk("ldr_ready", 32'(bus.ready_o), 1);
        step();
        bus.instr_valid_i = 1'b0;
        #1 chk("ld3_acc_cnt", 32'(bus.lq_count_o), 2);
        chk("ld3_acc_head", bus.lq_head_addr_o, 32'h200);
        bus.load_mem_resp_i = 1'b1;
        step();
        #1 chk("drain1_head", bus.lq_head_addr_o, 32'h300);
        step();
        bus.load_mem_resp_i = 1'b0;
        #1 chk("drain2_cnt", 32'(bus.lq_count_o), 0);
        chk("drain2_head", bus.lq_head_addr_o, 0);

        // RAW hazard on word alias
        req(32'hcad, 1'b0, 1'b1);
        step();
        req(32'hcac, 1'b1, 1'b0);
        #1 chk("raw_stall", 32'(bus.raw_stall_o), 1);
        chk("raw_ready", 32'(bus.ready_o), 0);
        req(32'hcb0, 1'b1, 1'b0);
        #1 chk("noalias_stall", 32'(bus.raw_stall_o), 0);
        chk("noalias_ready", 32'(bus.ready_o), 1);
        req(32'hcad, 1'b0, 1'b0);
        #1 chk("store_nostall", 32'(bus.raw_stall_o), 0);
        req(32'hcac, 1'b1, 1'b1);
        bus.store_mem_resp_i = 1'b1;
        #1 chk("raw_resp_stall", 32'(bus.raw_stall_o), 1);
        chk("raw_resp_ready", 32'(bus.ready_o), 0);
        step();
        bus.store_mem_resp_i = 1'b0;
        #1 chk("raw_clr_ready", 32'(bus.ready_o), 1);
        chk("raw_clr_lq", 32'(bus.lq_count_o), 0);
        step();
        bus.instr_valid_i = 1'b0;
        #1 chk("raw_acc_cnt", 32'(bus.lq_count_o), 1);
        chk("raw_acc_head", bus.lq_head_addr_o, 32'hcac);
        bus.load_mem_resp_i = 1'b1;
        step();
        bus.load_mem_resp_i = 1'b0;

        // store FIFO wraps at 3; retire order checked through the alias logic
        for (int k = 0; k < 7; k++) begin
            req(32'h1000 + 32'(k) * 4, 1'b0, 1'b1);
            bus.store_mem_resp_i = (k >= 2);
            step();
            bus.instr_valid_i = 1'b0;
            bus.store_mem_resp_i = 1'b0;
            #1 chk("wrap_cnt", 32'(bus.sq_count_o), (k == 0) ? 1 : 2);
            if (k >= 2) begin
                req(32'h1000 + 32'(k - 2) * 4, 1'b1, 1'b0);
                #1 chk("wrap_retired", 32'(bus.raw_stall_o), 0);
                req(32'h1000 + 32'(k - 1) * 4, 1'b1, 1'b0);
                #1 chk("wrap_pending", 32'(bus.raw_stall_o), 1);
            end
        end
        req(32'h101c, 1'b0, 1'b1);
        step();
        req(32'h2000, 1'b0, 1'b1);
        #1 chk("sq_full_cnt", 32'(bus.sq_count_o), 3);
        chk("sq_full_ready", 32'(bus.ready_o), 0);
        bus.instr_valid_i = 1'b0;
        bus.store_mem_resp_i = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            #1 chk("sq_drain_cnt", 32'(bus.sq_count_o), 32'(2 - j));
            req(32'h1000 + 32'(5 + j) * 4, 1'b1, 1'b0);
            #1 chk("sq_drain_retired", 32'(bus.raw_stall_o), 0);
            if (j < 2) begin
                req(32'h1000 + 32'(6 + j) * 4, 1'b1, 1'b0);
                #1 chk("sq_drain_pending", 32'(bus.raw_stall_o), 1);
            end
        end
        bus.store_mem_resp_i = 1'b0;

        // response with an empty queue
        bus.load_mem_resp_i = 1'b1;
        step();
        bus.load_mem_resp_i = 1'b0;
        #1 chk("err_lqcnt", 32'(bus.lq_count_o), 0);
        chk("err_set", 32'(bus.resp_err_o), 1);
        step();
        chk("err_sticky", 32'(bus.resp_err_o), 1);

        // async reset with traffic in flight
        req(32'h2000, 1'b0, 1'b1);
        step();
        req(32'h3000, 1'b1, 1'b1);
        step();
        req(32'h3004, 1'b1, 1'b1);
        step();
        req(32'h2000, 1'b1, 1'b1);
        #1 chk("pre_rst_lq", 32'(bus.lq_count_o), 2);
        chk("pre_rst_sq", 32'(bus.sq_count_o), 1);
        chk("pre_rst_raw", 32'(bus.raw_stall_o), 1);
        rst_i = 1'b1;
        #1 chk("arst_lq", 32'(bus.lq_count_o), 0);
        chk("arst_sq", 32'(bus.sq_count_o), 0);
        chk("arst_ready", 32'(bus.ready_o), 0);
        chk("arst_raw", 32'(bus.raw_stall_o), 0);
        chk("arst_err", 32'(bus.resp_err_o), 0);
        chk("arst_head", bus.lq_head_addr_o, 0);
        step();
        rst_i = 1'b0;
        #1 chk("post_rst_ready", 32'(bus.ready_o), 1);
        chk("post_rst_raw", 32'(bus.raw_stall_o), 0);
        bus.instr_valid_i = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
